// File: rtl/elink_rx_pkg.sv
// elink_rx_pkg: default widths and FSM state encoding shared by the elink frame receiver files
package elink_rx_pkg;
  localparam int FRAME_W_DEF = 76;
  localparam int CNT_W_DEF = 16;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DATA   = 3'd1;
  localparam logic [2:0] S_PARITY = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
endpackage

// File: rtl/elink_frame_receiver_if.sv
// elink_frame_receiver_if: reader handshake bundle
//   start_read_elink (reader->rx), payload, irq_elink, end_read_elink (rx->reader)
//   master = reader side, slave = receiver side
interface elink_frame_receiver_if
  import elink_rx_pkg::*;
#(parameter int FRAME_W = FRAME_W_DEF);
  logic               start_read_elink;
  logic [FRAME_W-1:0] payload;
  logic               irq_elink;
  logic               end_read_elink;
  modport master(output start_read_elink, input payload, irq_elink, end_read_elink);
  modport slave(input start_read_elink, output payload, irq_elink, end_read_elink);
endinterface

// File: rtl/elink_rx_deser.sv
// elink_rx_deser: start/data/[parity]/stop deserializer FSM with MSB-first shift register
//   in:  clk, rst, rxd
//   out: frame_valid/data (strobe during a good stop bit), frame_err, parity_err, busy
//   ELINK_RX_PARITY_EN adds an even-parity bit between data and stop
module elink_rx_deser
  import elink_rx_pkg::*;
#(parameter int FRAME_W = FRAME_W_DEF) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rxd,
  output logic               frame_valid,
  output logic               frame_err,
  output logic               parity_err,
  output logic [FRAME_W-1:0] data,
  output logic               busy
);
  localparam int CW = $clog2(FRAME_W);
  logic [2:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
`ifdef ELINK_RX_PARITY_EN
  logic perr_q, perr_d;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shift_d = shift_q;
    frame_valid = 1'b0;
    frame_err = 1'b0;
    parity_err = 1'b0;
`ifdef ELINK_RX_PARITY_EN
    perr_d = perr_q;
`endif
    case (state_q)
      S_IDLE: if (!rxd) begin
        state_d = S_DATA;
        cnt_d = '0;
      end
      S_DATA: begin
        shift_d = {shift_q[FRAME_W-2:0], rxd};
        cnt_d = cnt_q + 1'b1;
`ifdef ELINK_RX_PARITY_EN
        if (cnt_q == CW'(FRAME_W - 1)) state_d = S_PARITY;
`else
        if (cnt_q == CW'(FRAME_W - 1)) state_d = S_STOP;
`endif
      end
`ifdef ELINK_RX_PARITY_EN
      S_PARITY: begin
        perr_d = ^shift_q ^ rxd;
        state_d = S_STOP;
      end
`endif
      S_STOP: begin
`ifdef ELINK_RX_PARITY_EN
        parity_err = perr_q;
        frame_valid = rxd & !perr_q;
`else
        frame_valid = rxd;
`endif
        frame_err = !rxd;
        state_d = rxd ? S_IDLE : S_WAIT;
      end
      S_WAIT: if (rxd) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      shift_q <= '0;
`ifdef ELINK_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
`ifdef ELINK_RX_PARITY_EN
      perr_q <= perr_d;
`endif
    end
  end
  assign data = shift_q;
  assign busy = state_q != S_IDLE;
endmodule

// File: rtl/elink_frame_receiver.sv
// elink_frame_receiver: elink serial frame receiver with single-frame holding buffer
//   in:  clk, rst, rxd, rd.start_read_elink
//   out: rd.payload, rd.irq_elink, rd.end_read_elink, frame_err, ovf_err, parity_err, frame_cnt, busy
//   ELINK_RX_PARITY_EN enables the even-parity bit and parity_err
module elink_frame_receiver
  import elink_rx_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rxd,
  elink_frame_receiver_if.slave  rd,
  output logic                   frame_err,
  output logic                   ovf_err,
  output logic                   parity_err,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic                   busy
);
  logic fv, fe, pe, rd_ack, load;
  logic [FRAME_W-1:0] fdata;
  logic [FRAME_W-1:0] payload_q, payload_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic irq_q, irq_d, end_q, end_d, ferr_q, ferr_d, ovf_q, ovf_d, perr_q, perr_d;
  elink_rx_deser #(.FRAME_W(FRAME_W)) u_deser (
    .clk(clk), .rst(rst), .rxd(rxd),
    .frame_valid(fv), .frame_err(fe), .parity_err(pe), .data(fdata), .busy(busy)
  );
  // a read in the completion cycle frees the buffer in time for the new frame
  always_comb begin
    rd_ack = rd.start_read_elink & irq_q;
    load = fv & (!irq_q | rd_ack);
    payload_d = load ? fdata : payload_q;
    irq_d = load | (irq_q & !rd_ack);
    cnt_d = cnt_q + CNT_W'(load);
    ovf_d = fv & irq_q & !rd_ack;
    end_d = rd_ack;
    ferr_d = fe;
    perr_d = pe;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      payload_q <= '0;
      cnt_q <= '0;
      irq_q <= 1'b0;
      end_q <= 1'b0;
      ferr_q <= 1'b0;
      ovf_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      payload_q <= payload_d;
      cnt_q <= cnt_d;
      irq_q <= irq_d;
      end_q <= end_d;
      ferr_q <= ferr_d;
      ovf_q <= ovf_d;
      perr_q <= perr_d;
    end
  end
  assign rd.payload = payload_q;
  assign rd.irq_elink = irq_q;
  assign rd.end_read_elink = end_q;
  assign frame_err = ferr_q;
  assign ovf_err = ovf_q;
  assign parity_err = perr_q;
  assign frame_cnt = cnt_q;
endmodule

// File: tb/tb_elink_frame_receiver.sv
// tb_elink_frame_receiver: randomized self-checking bench against a frame-level buffer model
module tb_elink_frame_receiver;
  localparam int FW = 76;
  localparam int CW = 16;
`ifdef ELINK_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic frame_err, ovf_err, parity_err, busy;
  logic [CW-1:0] frame_cnt;
  int checks = 0;
  int errors = 0;
  logic [FW-1:0] m_pay;
  bit m_irq;
  logic [CW-1:0] m_cnt;
  logic irq_at_stop, busy_at_stop;
  bit bad_par = 1'b0;
  elink_frame_receiver_if #(.FRAME_W(FW)) rd();
  elink_frame_receiver #(.FRAME_W(FW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rd(rd),
    .frame_err(frame_err), .ovf_err(ovf_err), .parity_err(parity_err),
    .frame_cnt(frame_cnt), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic logic [FW-1:0] rnd();
    return FW'({$urandom, $urandom, $urandom});
  endfunction
  // buffer semantics at frame completion: a read frees the slot, otherwise a held frame blocks
  function automatic void model_complete(input logic [FW-1:0] f, input bit rdq, output bit e_end, output bit e_ovf);
    e_end = rdq & m_irq;
    e_ovf = m_irq & !rdq;
    if (!m_irq || rdq) begin
      m_pay = f;
      m_irq = 1'b1;
      m_cnt = m_cnt + 1'b1;
    end
  endfunction
  task automatic drive(input logic b);
    @(negedge clk);
    rxd = b;
  endtask
  // drives start, data MSB-first, optional parity, then the stop bit; returns in the stop cycle
  task automatic send_frame(input logic [FW-1:0] f, input logic stop, input bit rd_stop, input bit now);
    if (now) rxd = 1'b0;
    else drive(1'b0);
    for (int i = FW - 1; i >= 0; i--) drive(f[i]);
`ifdef ELINK_RX_PARITY_EN
    drive(^f ^ bad_par);
`endif
    @(negedge clk);
    irq_at_stop = rd.irq_elink;
    busy_at_stop = busy;
    rxd = stop;
    rd.start_read_elink = rd_stop;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    rxd = 1'b1;
    rd.start_read_elink = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd.payload, rd.irq_elink, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: payload %h irq %b cnt %0d, want all 0", rd.payload, rd.irq_elink, frame_cnt);
    end
    checks++;
    if ({rd.end_read_elink, frame_err, ovf_err, parity_err, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_pulses: end %b ferr %b ovf %b perr %b busy %b, want 0", rd.end_read_elink, frame_err, ovf_err, parity_err, busy);
    end
    rst = 1'b0;
    m_pay = '0;
    m_irq = 1'b0;
    m_cnt = '0;
  endtask
  task automatic test_basic();
    logic [FW-1:0] f;
    bit e_end, e_ovf;
    f = 76'hA_5A5A_5A5A_5A5A_5A5A_5;
    send_frame(f, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({irq_at_stop, busy_at_stop} !== 2'b01) begin
      errors++;
      $display("FAIL basic_stop_cycle: irq %b busy %b, want irq 0 busy 1", irq_at_stop, busy_at_stop);
    end
    @(negedge clk);
    model_complete(f, 1'b0, e_end, e_ovf);
    checks++;
    if ({rd.payload, rd.irq_elink, frame_cnt} !== {m_pay, m_irq, m_cnt}) begin
      errors++;
      $display("FAIL basic_accept: payload %h irq %b cnt %0d, want %h %b %0d", rd.payload, rd.irq_elink, frame_cnt, m_pay, m_irq, m_cnt);
    end
    checks++;
    if ({ovf_err, frame_err, parity_err, rd.end_read_elink, busy} !== {e_ovf, 1'b0, 1'b0, e_end, 1'b0}) begin
      errors++;
      $display("FAIL basic_flags: ovf %b ferr %b perr %b end %b busy %b, want %b 0 0 %b 0", ovf_err, frame_err, parity_err, rd.end_read_elink, busy, e_ovf, e_end);
    end
    @(negedge clk);
    checks++;
    if ({rd.payload, rd.irq_elink} !== {m_pay, m_irq}) begin
      errors++;
      $display("FAIL basic_hold: payload %h irq %b, want %h %b", rd.payload, rd.irq_elink, m_pay, m_irq);
    end
  endtask
  task automatic test_read();
    rd.start_read_elink = 1'b1;
    @(negedge clk);
    rd.start_read_elink = 1'b0;
    m_irq = 1'b0;
    checks++;
    if ({rd.end_read_elink, rd.irq_elink, rd.payload} !== {1'b1, m_irq, m_pay}) begin
      errors++;
      $display("FAIL read_ack: end %b irq %b payload %h, want 1 0 %h", rd.end_read_elink, rd.irq_elink, rd.payload, m_pay);
    end
    @(negedge clk);
    checks++;
    if (rd.end_read_elink !== 1'b0) begin
      errors++;
      $display("FAIL read_pulse_width: end %b, want 0", rd.end_read_elink);
    end
    rd.start_read_elink = 1'b1;
    @(negedge clk);
    rd.start_read_elink = 1'b0;
    checks++;
    if ({rd.end_read_elink, rd.irq_elink} !== 2'b00) begin
      errors++;
      $display("FAIL read_ignored: end %b irq %b, want 0 0", rd.end_read_elink, rd.irq_elink);
    end
  endtask
  task automatic test_overflow();
    logic [FW-1:0] f1, f2;
    bit e_end, e_ovf;
    f1 = rnd();
    f2 = rnd();
    send_frame(f1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    model_complete(f1, 1'b0, e_end, e_ovf);
    send_frame(f2, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    model_complete(f2, 1'b0, e_end, e_ovf);
    checks++;
    if ({ovf_err, rd.payload, rd.irq_elink, frame_cnt} !== {e_ovf, m_pay, m_irq, m_cnt}) begin
      errors++;
      $display("FAIL overflow: ovf %b payload %h irq %b cnt %0d, want %b %h %b %0d", ovf_err, rd.payload, rd.irq_elink, frame_cnt, e_ovf, m_pay, m_irq, m_cnt);
    end
    @(negedge clk);
    checks++;
    if (ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL overflow_pulse_width: ovf %b, want 0", ovf_err);
    end
    rd.start_read_elink = 1'b1;
    @(negedge clk);
    rd.start_read_elink = 1'b0;
    m_irq = 1'b0;
    checks++;
    if (rd.irq_elink !== m_irq) begin
      errors++;
      $display("FAIL overflow_clear: irq %b, want %b", rd.irq_elink, m_irq);
    end
  endtask
  task automatic test_frame_err();
    logic [FW-1:0] f;
    bit e_end, e_ovf;
    f = rnd();
    send_frame(f, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({frame_err, rd.irq_elink, frame_cnt, busy} !== {1'b1, m_irq, m_cnt, 1'b1}) begin
      errors++;
      $display("FAIL frame_err: ferr %b irq %b cnt %0d busy %b, want 1 %b %0d 1", frame_err, rd.irq_elink, frame_cnt, busy, m_irq, m_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({frame_err, busy} !== 2'b01) begin
        errors++;
        $display("FAIL frame_err_wait%0d: ferr %b busy %b, want 0 1", i, frame_err, busy);
      end
    end
    rxd = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_release: busy %b, want 0", busy);
    end
    f = rnd();
    send_frame(f, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    model_complete(f, 1'b0, e_end, e_ovf);
    checks++;
    if ({rd.payload, rd.irq_elink, frame_cnt} !== {m_pay, m_irq, m_cnt}) begin
      errors++;
      $display("FAIL frame_err_recover: payload %h irq %b cnt %0d, want %h %b %0d", rd.payload, rd.irq_elink, frame_cnt, m_pay, m_irq, m_cnt);
    end
  endtask
  task automatic test_coincident();
    logic [FW-1:0] f;
    bit e_end, e_ovf;
    f = rnd();
    send_frame(f, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rd.start_read_elink = 1'b0;
    model_complete(f, 1'b1, e_end, e_ovf);
    checks++;
    if ({rd.payload, rd.irq_elink, frame_cnt} !== {m_pay, m_irq, m_cnt}) begin
      errors++;
      $display("FAIL coincident_load: payload %h irq %b cnt %0d, want %h %b %0d", rd.payload, rd.irq_elink, frame_cnt, m_pay, m_irq, m_cnt);
    end
    checks++;
    if ({rd.end_read_elink, ovf_err} !== {e_end, e_ovf}) begin
      errors++;
      $display("FAIL coincident_flags: end %b ovf %b, want %b %b", rd.end_read_elink, ovf_err, e_end, e_ovf);
    end
  endtask
  task automatic test_back_to_back();
    logic [FW-1:0] f;
    bit e_end, e_ovf, rdq, now;
    now = 1'b0;
    for (int i = 0; i < 10; i++) begin
      f = rnd();
      rdq = 1'($urandom_range(0, 1));
      send_frame(f, 1'b1, rdq, now);
      @(negedge clk);
      rd.start_read_elink = 1'b0;
      model_complete(f, rdq, e_end, e_ovf);
      checks++;
      if ({rd.payload, rd.irq_elink, frame_cnt, rd.end_read_elink, ovf_err} !== {m_pay, m_irq, m_cnt, e_end, e_ovf}) begin
        errors++;
        $display("FAIL back_to_back%0d: payload %h irq %b cnt %0d end %b ovf %b, want %h %b %0d %b %b", i, rd.payload, rd.irq_elink, frame_cnt, rd.end_read_elink, ovf_err, m_pay, m_irq, m_cnt, e_end, e_ovf);
      end
      now = 1'($urandom_range(0, 1));
    end
  endtask
  task automatic test_parity();
    logic [FW-1:0] f;
    bit e_end, e_ovf, e_perr;
    rd.start_read_elink = 1'b1;
    @(negedge clk);
    rd.start_read_elink = 1'b0;
    m_irq = 1'b0;
    bad_par = 1'b1;
    f = rnd();
    send_frame(f, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    e_perr = PAR & bad_par;
    if (!e_perr) model_complete(f, 1'b0, e_end, e_ovf);
    checks++;
    if ({parity_err, rd.irq_elink, frame_cnt, rd.payload} !== {e_perr, m_irq, m_cnt, m_pay}) begin
      errors++;
      $display("FAIL parity_bad: perr %b irq %b cnt %0d payload %h, want %b %b %0d %h", parity_err, rd.irq_elink, frame_cnt, rd.payload, e_perr, m_irq, m_cnt, m_pay);
    end
    @(negedge clk);
    checks++;
    if (parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_pulse_width: perr %b, want 0", parity_err);
    end
    bad_par = 1'b0;
    rd.start_read_elink = 1'b1;
    @(negedge clk);
    rd.start_read_elink = 1'b0;
    m_irq = 1'b0;
    f = rnd();
    send_frame(f, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    model_complete(f, 1'b0, e_end, e_ovf);
    checks++;
    if ({parity_err, rd.irq_elink, frame_cnt, rd.payload} !== {1'b0, m_irq, m_cnt, m_pay}) begin
      errors++;
      $display("FAIL parity_good: perr %b irq %b cnt %0d payload %h, want 0 %b %0d %h", parity_err, rd.irq_elink, frame_cnt, rd.payload, m_irq, m_cnt, m_pay);
    end
  endtask
  task automatic test_rst_mid();
    logic [FW-1:0] f;
    bit e_end, e_ovf;
    drive(1'b0);
    for (int i = 0; i < 30; i++) drive(1'($urandom_range(0, 1)));
    @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_pay = '0;
    m_irq = 1'b0;
    m_cnt = '0;
    checks++;
    if ({rd.payload, rd.irq_elink, frame_cnt, rd.end_read_elink, frame_err, ovf_err, parity_err, busy} !== '0) begin
      errors++;
      $display("FAIL rst_mid: payload %h irq %b cnt %0d end %b ferr %b ovf %b perr %b busy %b, want all 0", rd.payload, rd.irq_elink, frame_cnt, rd.end_read_elink, frame_err, ovf_err, parity_err, busy);
    end
    f = rnd();
    send_frame(f, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    model_complete(f, 1'b0, e_end, e_ovf);
    checks++;
    if ({rd.payload, rd.irq_elink, frame_cnt, frame_err} !== {m_pay, m_irq, m_cnt, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_recover: payload %h irq %b cnt %0d ferr %b, want %h %b %0d 0", rd.payload, rd.irq_elink, frame_cnt, frame_err, m_pay, m_irq, m_cnt);
    end
  endtask
  initial begin
    rd.start_read_elink = 1'b0;
    test_reset();
    test_basic();
    test_read();
    test_overflow();
    test_frame_err();
    test_coincident();
    test_back_to_back();
    test_parity();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
